align_shifter: RTL and testbench
================================

Name: align_shifter

Overview:
- Pipelined right-shift alignment unit for the shared FP datapath.
- Denormalizes a 28-bit mantissa field by a given shift amount and collects shifted-out bits into sticky flags.
- FP32 mode: one 28-bit lane. Dual-half mode (any fmt other than FP32): two independent 14-bit lanes, h = bits [27:14], l = bits [13:0].
- Sits ahead of the shared adder, aligning the smaller operand. It is the inverse-direction companion of the leading-zero normalizer.

Parameters:
- DATA_W, 28, total datapath width; must be even. Lane width LANE_W = DATA_W/2 is derived as a localparam.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  input request valid
- in_ready  out  1  unit can accept input this cycle
- fmt  in  fp_fmt_e  format; FP32 = single lane, otherwise dual lane
- x  in  DATA_W  mantissa field(s) to shift
- shamt_h  in  5  right-shift amount for the FP32 lane or lane h
- shamt_l  in  5  right-shift amount for lane l; ignored in FP32
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_fmt  out  fp_fmt_e  fmt carried with the result
- r  out  DATA_W  shifted result
- sticky_h  out  1  OR of bits shifted out of the FP32 lane / lane h
- sticky_l  out  1  OR of bits shifted out of lane l; equals sticky_h in FP32

Behaviour:
- Reset: synchronous, active-low on clk. While rst_n=0, both stage valids clear and all data registers clear.
  - Outputs after reset: out_valid=0, r=0, sticky_h=0, sticky_l=0, out_fmt=FP32. in_ready=1 on the first cycle after release.
  - Reset asserted mid-operation discards all in-flight items; out_valid=0 on the next edge.
- Handshake: a transfer occurs when valid && ready on the same edge.
  - out_valid, r, sticky_*, out_fmt are held stable while out_valid=1 and out_ready=0.
  - in_valid does not depend on in_ready.
- Pipeline: two register stages, latency 2 cycles from input acceptance to out_valid. Throughput is 1 per cycle when out_ready=1.
  - Stage 1 (coarse) applies shift bits [4:3] (by 16, by 8) and a partial sticky.
  - Stage 2 (fine) applies shift bits [2:0] (by 4, 2, 1), completes the sticky, and registers the result.
- Flow control:
  - s2_adv = !s2_valid || out_ready
  - s1_adv = !s1_valid || s2_adv
  - in_ready = s1_adv (combinational from out_ready; permitted)
  - A stage loads only when it advances. No bubbles are inserted and no item is lost or duplicated under arbitrary out_ready patterns.
- FP32 mode:
  - r = x >> shamt_h, zero-filled from bit 27.
  - shamt_h >= 28 gives r=0 and sticky_h = |x.
  - shamt_l is ignored; sticky_l = sticky_h.
- Dual mode:
  - Each lane shifts independently, zero-filled at its own MSB (bit 27 for h, bit 13 for l).
  - Lane h never receives bits from lane l. Bits shifted out of lane h go to sticky_h only; bits shifted out of lane l go to sticky_l only.
  - A lane shift >= 14 gives that lane = 0 and its sticky = OR of the lane's input bits.
- fmt and both shift amounts are captured with the data at stage 1. A fmt change between back-to-back items takes effect per item.

Optional Feature:
- Macro: ALIGN_STICKY_EN.
- Defined: sticky_h and sticky_l are computed as above.
- Undefined: sticky_h and sticky_l are tied to 0, shifted-out bits are discarded (truncation), and no sticky OR-trees or sticky registers are synthesized.
- r, latency and handshake are identical in both builds.

Decomposition:
- Shared package: fp_fmt_e (FP32 plus half formats), FP_MANT_W=28, FP_LANE_W=14, FP_SHAMT_W=5.
- Sub-module: lane_rshift_sticky, a combinational right shift of one lane by a partial amount that also returns the OR of the bits it drops. It is instantiated once per lane per stage; the FP32 path concatenates the two lanes across the boundary.

Test Plan:
- FP32, x=28'h8000000, shamt_h=27 -> r=28'h0000001, sticky_h=0, out_valid exactly 2 cycles after acceptance.
- FP32, x=28'h8000001, shamt_h=28 -> r=0, sticky_h=1, sticky_l=1. With shamt_h=31 -> same result.
- Dual, x=28'h8000003, shamt_h=1, shamt_l=1 -> r=28'h4000001, sticky_h=0, sticky_l=1. Confirms no lane-h bit leaks into lane l.
- Dual, lane h=14'h3FFF, lane l=14'h0000, shamt_h=14, shamt_l=5 -> r=0, sticky_h=1, sticky_l=0.
- Backpressure: 4 back-to-back inputs with out_ready=0 for 3 cycles. in_ready drops after 2 items are accepted; all 4 outputs emerge in order, unchanged while stalled, with no duplicates.
- rst_n=0 for 1 cycle while out_valid=1 and stage 1 is full -> next cycle out_valid=0, r=0. A fresh input then yields its result after 2 cycles with no stale item.

Source files
------------

// File: rtl/align_shifter_pkg.sv
// Shared FP datapath types and widths for the alignment shifter.
package align_shifter_pkg;

    localparam int unsigned FP_MANT_W  = 28;
    localparam int unsigned FP_LANE_W  = 14;
    localparam int unsigned FP_SHAMT_W = 5;

    typedef enum logic [1:0] {
        FMT_FP32 = 2'd0,
        FMT_FP16 = 2'd1,
        FMT_BF16 = 2'd2
    } fp_fmt_e;

    // Stage 1 handles the by-16/by-8 part of a shift amount.
    function automatic logic [FP_SHAMT_W-1:0] coarse_amt(input logic [FP_SHAMT_W-1:0] s);
        return {s[4:3], 3'b000};
    endfunction

    // Stage 2 handles the by-4/2/1 part of a shift amount.
    function automatic logic [FP_SHAMT_W-1:0] fine_amt(input logic [2:0] s);
        return {2'b00, s};
    endfunction

endpackage

// File: rtl/lane_rshift_sticky.sv
// One-lane right shift with bits entering from fill_i; sticky_c (ALIGN_STICKY_EN)
// is the OR of every {fill_i, d_i} bit that falls below the lane.
module lane_rshift_sticky
    import align_shifter_pkg::*;
#(
    parameter int unsigned W = FP_LANE_W
) (
    input  logic [W-1:0]          d_i,
    input  logic [W-1:0]          fill_i,
    input  logic [FP_SHAMT_W-1:0] amt_i,
    output logic [W-1:0]          q_c
`ifdef ALIGN_STICKY_EN
    ,
    output logic                  sticky_c
`endif
);

    logic [2*W-1:0] cat;

    assign cat = {fill_i, d_i};
    assign q_c = W'(cat >> amt_i);

`ifdef ALIGN_STICKY_EN
    always_comb begin
        sticky_c = 1'b0;
        for (int i = 0; i < int'(2 * W); i++) begin
            if (i < int'(amt_i)) begin
                sticky_c = sticky_c | cat[i];
            end
        end
    end
`endif

endmodule

// File: rtl/align_shifter.sv
// Two-stage right-shift alignment unit: one 28-bit lane in FP32, two 14-bit lanes
// otherwise. Sticky collection is built only when ALIGN_STICKY_EN is defined.
module align_shifter
    import align_shifter_pkg::*;
#(
    parameter int unsigned DATA_W = FP_MANT_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  fp_fmt_e               fmt,
    input  logic [DATA_W-1:0]     x,
    input  logic [FP_SHAMT_W-1:0] shamt_h,
    input  logic [FP_SHAMT_W-1:0] shamt_l,
    output logic                  out_valid,
    input  logic                  out_ready,
    output fp_fmt_e               out_fmt,
    output logic [DATA_W-1:0]     r,
    output logic                  sticky_h,
    output logic                  sticky_l
);

    localparam int unsigned LANE_W = DATA_W / 2;

    logic s1_adv, s2_adv;

    logic                  s1_valid_q, s1_valid_d;
    fp_fmt_e               s1_fmt_q, s1_fmt_d;
    logic [DATA_W-1:0]     s1_data_q, s1_data_d;
    logic [2:0]            s1_fine_h_q, s1_fine_h_d;
    logic [2:0]            s1_fine_l_q, s1_fine_l_d;

    logic                  s2_valid_q, s2_valid_d;
    fp_fmt_e               s2_fmt_q, s2_fmt_d;
    logic [DATA_W-1:0]     s2_r_q, s2_r_d;

    logic                  in_fp32, s1_fp32;
    logic [LANE_W-1:0]     c1_fill_l, c1_h, c1_l;
    logic [LANE_W-1:0]     c2_fill_l, c2_h, c2_l;
    logic [FP_SHAMT_W-1:0] c1_amt_l;

    assign s2_adv   = !s2_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = s1_adv;

    // In FP32 the l lane takes the h lane as fill so the shift crosses the boundary.
    assign in_fp32   = (fmt == FMT_FP32);
    assign c1_fill_l = in_fp32 ? x[DATA_W-1:LANE_W] : '0;
    assign c1_amt_l  = in_fp32 ? shamt_h : shamt_l;

    assign s1_fp32   = (s1_fmt_q == FMT_FP32);
    assign c2_fill_l = s1_fp32 ? s1_data_q[DATA_W-1:LANE_W] : '0;

`ifdef ALIGN_STICKY_EN
    logic c1_st_h, c1_st_l, c2_st_h, c2_st_l;
    logic s1_st_h_q, s1_st_h_d, s1_st_l_q, s1_st_l_d;
    logic s2_st_h_q, s2_st_h_d, s2_st_l_q, s2_st_l_d;
`endif

    lane_rshift_sticky #(.W(LANE_W)) u_s1_h (
        .d_i      (x[DATA_W-1:LANE_W]),
        .fill_i   ('0),
        .amt_i    (coarse_amt(shamt_h)),
        .q_c      (c1_h)
`ifdef ALIGN_STICKY_EN
        ,
        .sticky_c (c1_st_h)
`endif
    );

    lane_rshift_sticky #(.W(LANE_W)) u_s1_l (
        .d_i      (x[LANE_W-1:0]),
        .fill_i   (c1_fill_l),
        .amt_i    (coarse_amt(c1_amt_l)),
        .q_c      (c1_l)
`ifdef ALIGN_STICKY_EN
        ,
        .sticky_c (c1_st_l)
`endif
    );

    lane_rshift_sticky #(.W(LANE_W)) u_s2_h (
        .d_i      (s1_data_q[DATA_W-1:LANE_W]),
        .fill_i   ('0),
        .amt_i    (fine_amt(s1_fine_h_q)),
        .q_c      (c2_h)
`ifdef ALIGN_STICKY_EN
        ,
        .sticky_c (c2_st_h)
`endif
    );

    lane_rshift_sticky #(.W(LANE_W)) u_s2_l (
        .d_i      (s1_data_q[LANE_W-1:0]),
        .fill_i   (c2_fill_l),
        .amt_i    (fine_amt(s1_fine_l_q)),
        .q_c      (c2_l)
`ifdef ALIGN_STICKY_EN
        ,
        .sticky_c (c2_st_l)
`endif
    );

    // Next-state: a stage loads only when it advances.
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_fmt_d    = s1_fmt_q;
        s1_data_d   = s1_data_q;
        s1_fine_h_d = s1_fine_h_q;
        s1_fine_l_d = s1_fine_l_q;
        s2_valid_d  = s2_valid_q;
        s2_fmt_d    = s2_fmt_q;
        s2_r_d      = s2_r_q;
`ifdef ALIGN_STICKY_EN
        s1_st_h_d   = s1_st_h_q;
        s1_st_l_d   = s1_st_l_q;
        s2_st_h_d   = s2_st_h_q;
        s2_st_l_d   = s2_st_l_q;
`endif
        if (s1_adv) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_fmt_d    = fmt;
                s1_data_d   = {c1_h, c1_l};
                s1_fine_h_d = shamt_h[2:0];
                s1_fine_l_d = c1_amt_l[2:0];
`ifdef ALIGN_STICKY_EN
                s1_st_h_d   = in_fp32 ? c1_st_l : c1_st_h;
                s1_st_l_d   = c1_st_l;
`endif
            end
        end
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_fmt_d  = s1_fmt_q;
                s2_r_d    = {c2_h, c2_l};
`ifdef ALIGN_STICKY_EN
                s2_st_h_d = s1_st_h_q | (s1_fp32 ? c2_st_l : c2_st_h);
                s2_st_l_d = s1_st_l_q | c2_st_l;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_fmt_q    <= FMT_FP32;
            s1_data_q   <= '0;
            s1_fine_h_q <= '0;
            s1_fine_l_q <= '0;
            s2_valid_q  <= 1'b0;
            s2_fmt_q    <= FMT_FP32;
            s2_r_q      <= '0;
`ifdef ALIGN_STICKY_EN
            s1_st_h_q   <= 1'b0;
            s1_st_l_q   <= 1'b0;
            s2_st_h_q   <= 1'b0;
            s2_st_l_q   <= 1'b0;
`endif
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_fmt_q    <= s1_fmt_d;
            s1_data_q   <= s1_data_d;
            s1_fine_h_q <= s1_fine_h_d;
            s1_fine_l_q <= s1_fine_l_d;
            s2_valid_q  <= s2_valid_d;
            s2_fmt_q    <= s2_fmt_d;
            s2_r_q      <= s2_r_d;
`ifdef ALIGN_STICKY_EN
            s1_st_h_q   <= s1_st_h_d;
            s1_st_l_q   <= s1_st_l_d;
            s2_st_h_q   <= s2_st_h_d;
            s2_st_l_q   <= s2_st_l_d;
`endif
        end
    end

    assign out_valid = s2_valid_q;
    assign out_fmt   = s2_fmt_q;
    assign r         = s2_r_q;

`ifdef ALIGN_STICKY_EN
    assign sticky_h = s2_st_h_q;
    assign sticky_l = s2_st_l_q;
`else
    assign sticky_h = 1'b0;
    assign sticky_l = 1'b0;
`endif

endmodule

// File: tb/tb_align_shifter.sv
// Directed vector bench for align_shifter: single items, backpressure and mid-flight reset.
module tb_align_shifter;
    import align_shifter_pkg::*;

`ifdef ALIGN_STICKY_EN
    localparam bit STK = 1'b1;
`else
    localparam bit STK = 1'b0;
`endif
    localparam int NV = 16;

    typedef struct {
        fp_fmt_e     fmt;
        logic [27:0] x;
        logic [4:0]  sh;
        logic [4:0]  sl;
        logic [27:0] r;
        logic        st_h;
        logic        st_l;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    fp_fmt_e     fmt;
    logic [27:0] x;
    logic [4:0]  shamt_h;
    logic [4:0]  shamt_l;
    logic        out_valid;
    logic        out_ready;
    fp_fmt_e     out_fmt;
    logic [27:0] r;
    logic        sticky_h;
    logic        sticky_l;

    int   total = 0;
    int   bad   = 0;
    vec_t vecs [NV];

    align_shifter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .fmt       (fmt),
        .x         (x),
        .shamt_h   (shamt_h),
        .shamt_l   (shamt_l),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_fmt   (out_fmt),
        .r         (r),
        .sticky_h  (sticky_h),
        .sticky_l  (sticky_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic drive(input int i);
        fmt     = vecs[i].fmt;
        x       = vecs[i].x;
        shamt_h = vecs[i].sh;
        shamt_l = vecs[i].sl;
    endtask

    task automatic chk_out(input int i, input string tag);
        chk($sformatf("%s_r[%0d]", tag, i), 32'(r), 32'(vecs[i].r));
        chk($sformatf("%s_sth[%0d]", tag, i), 32'(sticky_h), 32'(vecs[i].st_h & STK));
        chk($sformatf("%s_stl[%0d]", tag, i), 32'(sticky_l), 32'(vecs[i].st_l & STK));
        chk($sformatf("%s_fmt[%0d]", tag, i), 32'(out_fmt), 32'(vecs[i].fmt));
    endtask

    // Present one item into an empty pipeline and check latency and result.
    task automatic run_vec(input int i);
        int lat;
        @(negedge clk);
        drive(i);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        chk($sformatf("latency[%0d]", i), 32'(lat), 32'd2);
        chk_out(i, "vec");
    endtask

    initial begin
        int          order [4];
        int          sent, recv, cyc;
        logic [27:0] held_r;
        fp_fmt_e     held_fmt;
        logic        stalled_prev;

        vecs[0]  = '{FMT_FP32, 28'h8000000, 5'd27, 5'd0,  28'h0000001, 1'b0, 1'b0};
        vecs[1]  = '{FMT_FP32, 28'h8000001, 5'd28, 5'd0,  28'h0000000, 1'b1, 1'b1};
        vecs[2]  = '{FMT_FP32, 28'h8000001, 5'd31, 5'd0,  28'h0000000, 1'b1, 1'b1};
        vecs[3]  = '{FMT_FP16, 28'h8000003, 5'd1,  5'd1,  28'h4000001, 1'b0, 1'b1};
        vecs[4]  = '{FMT_FP16, 28'hFFFC000, 5'd14, 5'd5,  28'h0000000, 1'b1, 1'b0};
        vecs[5]  = '{FMT_FP32, 28'hABCDEF1, 5'd0,  5'd0,  28'hABCDEF1, 1'b0, 1'b0};
        vecs[6]  = '{FMT_FP32, 28'h0000FFF, 5'd4,  5'd0,  28'h00000FF, 1'b1, 1'b1};
        vecs[7]  = '{FMT_FP32, 28'h0001000, 5'd12, 5'd0,  28'h0000001, 1'b0, 1'b0};
        vecs[8]  = '{FMT_FP32, 28'h0004000, 5'd1,  5'd0,  28'h0002000, 1'b0, 1'b0};
        vecs[9]  = '{FMT_BF16, 28'h0004000, 5'd1,  5'd0,  28'h0000000, 1'b1, 1'b0};
        vecs[10] = '{FMT_BF16, 28'h8003FFF, 5'd13, 5'd13, 28'h0004001, 1'b0, 1'b1};
        vecs[11] = '{FMT_FP16, 28'h0004001, 5'd0,  5'd31, 28'h0004000, 1'b0, 1'b1};
        vecs[12] = '{FMT_FP32, 28'h0000010, 5'd4,  5'd31, 28'h0000001, 1'b0, 1'b0};
        vecs[13] = '{FMT_FP32, 28'hF000000, 5'd25, 5'd0,  28'h0000007, 1'b1, 1'b1};
        vecs[14] = '{FMT_BF16, 28'hFFFC0FF, 5'd8,  5'd8,  28'h00FC000, 1'b1, 1'b1};
        vecs[15] = '{FMT_FP16, 28'h0000000, 5'd31, 5'd31, 28'h0000000, 1'b0, 1'b0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        fmt       = FMT_FP32;
        x         = '0;
        shamt_h   = '0;
        shamt_l   = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_r", 32'(r), 32'd0);
        chk("rst_sticky", 32'({sticky_h, sticky_l}), 32'd0);
        chk("rst_fmt", 32'(out_fmt), 32'(FMT_FP32));
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < NV; i++) run_vec(i);

        // Backpressure: four back-to-back items, output stalled for three cycles.
        order[0] = 1; order[1] = 3; order[2] = 6; order[3] = 10;
        sent = 0;
        recv = 0;
        cyc  = 0;
        stalled_prev = 1'b0;
        held_r   = '0;
        held_fmt = FMT_FP32;
        while (recv < 4 && cyc < 40) begin
            logic acc, got;
            @(negedge clk);
            out_ready = (cyc >= 5);
            in_valid  = (sent < 4);
            if (sent < 4) drive(order[sent]);
            #1;
            if (cyc == 2) begin
                chk("bp_in_ready_drop", 32'(in_ready), 32'd0);
                chk("bp_accepted", 32'(sent), 32'd2);
            end
            if (out_valid && stalled_prev) begin
                chk("bp_hold_r", 32'(r), 32'(held_r));
                chk("bp_hold_fmt", 32'(out_fmt), 32'(held_fmt));
            end
            stalled_prev = out_valid && !out_ready;
            held_r   = r;
            held_fmt = out_fmt;
            acc = in_valid && in_ready;
            got = out_valid && out_ready;
            if (got) begin
                chk_out(order[recv], "bp");
                recv++;
            end
            @(posedge clk);
            if (acc) sent++;
            cyc++;
        end
        chk("bp_received", 32'(recv), 32'd4);
        in_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("bp_no_dup", 32'(out_valid), 32'd0);
        end

        // Reset with both stages full discards everything in flight.
        out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            drive(k == 0 ? 6 : 13);
            in_valid = 1'b1;
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("mid_full_out_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_r", 32'(r), 32'd0);
        run_vec(8);
        repeat (3) begin
            @(negedge clk);
            chk("mid_no_stale", 32'(out_valid), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
